// File: rtl/pico_mips_pkg.sv
// rtl/pico_mips_pkg.sv - shared types for the picoMIPS I/O sequencer
package pico_mips_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_WAIT  = 2'd1,
      IN_WB    = 2'd2,
      OUT_WAIT = 2'd3
   } io_state_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating handshake wait counter with expiry flag
module wait_timer #(
   parameter int TimeoutCycles = 0
) (
   input  logic clk,
   input  logic n_reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TimeoutCycles);

   logic [CW-1:0] count;

   // count waiting cycles, holding at the limit so the value never wraps
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + CW'(1);
      end
   end

   // expiry is flagged during the last allowed waiting cycle itself
   generate
      if (TimeoutCycles == 0) begin : g_no_timeout
         assign expired = 1'b0;
      end else begin : g_timeout
         assign expired = enable && (count >= CW'(TimeoutCycles - 1));
      end
   endgenerate

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - STIN/LOUT valid/ready sequencer with PC stall
module io_controller
   import pico_mips_pkg::*;
#(
   parameter int N             = 8,
   parameter int InBusSz       = 10,
   parameter int TimeoutCycles = 0
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               read_in,
   input  logic               write_out,
   input  logic [InBusSz-1:0] in_bus,
   input  logic               in_valid,
   output logic               in_ack,
   input  logic [N-1:0]       out_data,
   output logic [N-1:0]       out_bus,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       in_data,
   output logic               stall,
   output logic               reg_write_en,
   output logic               timeout
);

   io_state_t state;
   logic      timer_clear;
   logic      timer_enable;
   logic      expired;

   assign timer_clear  = (state == IDLE);
   assign timer_enable = (state == IN_WAIT) || (state == OUT_WAIT);

   wait_timer #(
      .TimeoutCycles(TimeoutCycles)
   ) u_wait_timer (
      .clk    (clk),
      .n_reset(n_reset),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expired(expired)
   );

   // stall/ack/write decode; in_valid deliberately never reaches these, so an
   // in_valid arriving in the expiring cycle loses to the timeout
   always_comb begin
      stall        = 1'b0;
      in_ack       = 1'b0;
      reg_write_en = 1'b0;
      unique case (state)
         IDLE:     stall = read_in | write_out;
         IN_WAIT:  stall = !expired;
         IN_WB: begin
            in_ack       = 1'b1;
            reg_write_en = 1'b1;
         end
         OUT_WAIT: stall = !out_ready && !expired;
         default:  stall = 1'b0;
      endcase
   end

   // transfer sequencing with registered data/valid/timeout outputs
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         out_bus   <= '0;
         out_valid <= 1'b0;
         in_data   <= '0;
         timeout   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (read_in) begin
                  state <= IN_WAIT;
               end else if (write_out) begin
                  out_bus   <= out_data;
                  out_valid <= 1'b1;
                  state     <= OUT_WAIT;
               end
            end
            IN_WAIT: begin
               if (expired) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else if (in_valid) begin
                  in_data <= N'(in_bus);
                  state   <= IN_WB;
               end
            end
            IN_WB: state <= IDLE;
            OUT_WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (expired) begin
                  timeout   <= 1'b1;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - self-checking bench for io_controller
module tb_io_controller;

   localparam int N  = 8;
   localparam int IB = 10;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          read_in = 1'b0;
   logic          write_out = 1'b0;
   logic [IB-1:0] in_bus = '0;
   logic          in_valid = 1'b0;
   logic          in_ack;
   logic [N-1:0]  out_data = '0;
   logic [N-1:0]  out_bus;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  in_data;
   logic          stall;
   logic          reg_write_en;
   logic          timeout;

   int checks = 0;
   int failures = 0;

   logic          exp_timeout;
   logic [N-1:0]  exp_out_bus;
   logic [N-1:0]  exp_in_data;

   io_controller #(.N(N), .InBusSz(IB), .TimeoutCycles(T)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .read_in     (read_in),
      .write_out   (write_out),
      .in_bus      (in_bus),
      .in_valid    (in_valid),
      .in_ack      (in_ack),
      .out_data    (out_data),
      .out_bus     (out_bus),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .in_data     (in_data),
      .stall       (stall),
      .reg_write_en(reg_write_en),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // STIN lasting until in_valid after d cycles; returns total cycles taken
   task automatic do_stin(input int d, input logic [IB-1:0] val, input logic wr_also, output int n);
      int  j;
      bit  to;
      logic [N-1:0] want_data;
      j  = (d < 1) ? 1 : d;
      to = (j >= T);
      n  = to ? T + 1 : j + 2;
      want_data = val[N-1:0];
      read_in   = 1'b1;
      write_out = wr_also;
      out_data  = N'($urandom);
      for (int c = 1; c <= n; c++) begin
         in_valid = (c > d);
         in_bus   = (!to && c == j + 1) ? val : IB'($urandom);
         @(negedge clk);
         checks += 6;
         if (stall !== (c < n)) begin
            failures++; $display("FAIL stin_stall d=%0d c=%0d got=%b exp=%b", d, c, stall, c < n);
         end
         if (in_ack !== (!to && c == n)) begin
            failures++; $display("FAIL stin_ack d=%0d c=%0d got=%b exp=%b", d, c, in_ack, !to && c == n);
         end
         if (reg_write_en !== (!to && c == n)) begin
            failures++; $display("FAIL stin_rwe d=%0d c=%0d got=%b exp=%b", d, c, reg_write_en, !to && c == n);
         end
         if (in_data !== ((!to && c == n) ? want_data : exp_in_data)) begin
            failures++; $display("FAIL stin_data d=%0d c=%0d got=%h exp=%h", d, c, in_data,
                                 (!to && c == n) ? want_data : exp_in_data);
         end
         if (out_bus !== exp_out_bus || out_valid !== 1'b0) begin
            failures++; $display("FAIL stin_out c=%0d got=%h/%b exp=%h/0", c, out_bus, out_valid, exp_out_bus);
         end
         if (timeout !== exp_timeout) begin
            failures++; $display("FAIL stin_timeout c=%0d got=%b exp=%b", c, timeout, exp_timeout);
         end
         step();
      end
      if (to) exp_timeout = 1'b1;
      else exp_in_data = want_data;
   endtask

   // LOUT with out_ready low for r waiting cycles; returns total cycles taken
   task automatic do_lout(input int r, input logic [N-1:0] val, output int n);
      bit to;
      to = (r >= T);
      n  = to ? T + 1 : r + 2;
      read_in   = 1'b0;
      write_out = 1'b1;
      for (int c = 1; c <= n; c++) begin
         out_data  = (c == 1) ? val : N'($urandom);
         out_ready = (c == 1) ? 1'($urandom) : (c >= r + 2);
         in_valid  = 1'($urandom);
         @(negedge clk);
         checks += 5;
         if (stall !== (c < n)) begin
            failures++; $display("FAIL lout_stall r=%0d c=%0d got=%b exp=%b", r, c, stall, c < n);
         end
         if (out_valid !== (c >= 2)) begin
            failures++; $display("FAIL lout_valid r=%0d c=%0d got=%b exp=%b", r, c, out_valid, c >= 2);
         end
         if (out_bus !== ((c >= 2) ? val : exp_out_bus)) begin
            failures++; $display("FAIL lout_bus r=%0d c=%0d got=%h exp=%h", r, c, out_bus,
                                 (c >= 2) ? val : exp_out_bus);
         end
         if (in_ack !== 1'b0 || reg_write_en !== 1'b0) begin
            failures++; $display("FAIL lout_ack c=%0d got=%b/%b exp=0/0", c, in_ack, reg_write_en);
         end
         if (timeout !== exp_timeout) begin
            failures++; $display("FAIL lout_timeout c=%0d got=%b exp=%b", c, timeout, exp_timeout);
         end
         step();
      end
      exp_out_bus = val;
      if (to) exp_timeout = 1'b1;
   endtask

   task automatic do_idle(input int k);
      read_in   = 1'b0;
      write_out = 1'b0;
      for (int c = 0; c < k; c++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_bus    = IB'($urandom);
         @(negedge clk);
         checks += 3;
         if (stall !== 1'b0 || out_valid !== 1'b0 || in_ack !== 1'b0 || reg_write_en !== 1'b0) begin
            failures++; $display("FAIL idle_ctrl got=%b%b%b%b exp=0000", stall, out_valid, in_ack, reg_write_en);
         end
         if (out_bus !== exp_out_bus || in_data !== exp_in_data) begin
            failures++; $display("FAIL idle_data got=%h/%h exp=%h/%h", out_bus, in_data, exp_out_bus, exp_in_data);
         end
         if (timeout !== exp_timeout) begin
            failures++; $display("FAIL idle_timeout got=%b exp=%b", timeout, exp_timeout);
         end
         step();
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      step();
      checks += 3;
      if (out_bus !== 8'h00 || in_data !== 8'h00 || out_valid !== 1'b0 || timeout !== 1'b0) begin
         failures++; $display("FAIL reset_regs got=%h/%h/%b/%b exp=00/00/0/0", out_bus, in_data, out_valid, timeout);
      end
      if (stall !== 1'b0 || in_ack !== 1'b0 || reg_write_en !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b%b%b exp=000", stall, in_ack, reg_write_en);
      end
      read_in = 1'b1;
      #1;
      if (stall !== 1'b1) begin
         failures++; $display("FAIL reset_stall_strobe got=%b exp=1", stall);
      end
      read_in = 1'b0;
      exp_timeout = 1'b0; exp_out_bus = '0; exp_in_data = '0;
      step();
      n_reset = 1'b1;
      do_idle(2);
   endtask

   task automatic test_stin_ready();
      int n;
      do_stin(0, 10'h2A5, 1'b0, n);
      checks++;
      if (n != 3 || in_data !== 8'hA5) begin
         failures++; $display("FAIL stin_ready got=%0d/%h exp=3/a5", n, in_data);
      end
      do_idle(1);
   endtask

   task automatic test_stin_delayed();
      int n;
      do_stin(5, IB'($urandom), 1'b0, n);
      do_idle(1);
   endtask

   task automatic test_lout();
      int n;
      do_lout(4, 8'h3C, n);
      do_idle(2);
      checks++;
      if (out_bus !== 8'h3C) begin
         failures++; $display("FAIL lout_hold got=%h exp=3c", out_bus);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_stin(1000, IB'($urandom), 1'b0, n);
      checks++;
      if (timeout !== 1'b1) begin
         failures++; $display("FAIL timeout_set got=%b exp=1", timeout);
      end
      do_idle(1);
      do_stin(2, IB'($urandom), 1'b0, n);
      do_stin(T, IB'($urandom), 1'b0, n);
      do_stin(T - 1, IB'($urandom), 1'b0, n);
      do_lout(T, N'($urandom), n);
      do_lout(T - 1, N'($urandom), n);
      do_idle(1);
   endtask

   task automatic test_both_strobes();
      int n;
      do_stin(0, IB'($urandom), 1'b1, n);
      do_stin(3, IB'($urandom), 1'b1, n);
      do_idle(1);
   endtask

   task automatic test_back_to_back();
      int n;
      do_stin(0, IB'($urandom), 1'b0, n);
      do_stin(2, IB'($urandom), 1'b0, n);
      do_lout(0, N'($urandom), n);
      do_lout(1, N'($urandom), n);
      do_stin(0, IB'($urandom), 1'b0, n);
      do_idle(1);
   endtask

   task automatic test_reset_mid();
      read_in = 1'b1; write_out = 1'b0; in_valid = 1'b0;
      step(); step(); step();
      #1 n_reset = 1'b0;
      #1;
      checks += 2;
      if (in_ack !== 1'b0 || reg_write_en !== 1'b0 || out_valid !== 1'b0 || in_data !== 8'h00) begin
         failures++; $display("FAIL rst_in_wait got=%b%b%b/%h exp=000/00", in_ack, reg_write_en, out_valid, in_data);
      end
      read_in = 1'b0;
      #1;
      if (stall !== 1'b0) begin
         failures++; $display("FAIL rst_in_stall got=%b exp=0", stall);
      end
      step();
      n_reset = 1'b1;
      exp_timeout = 1'b0; exp_out_bus = '0; exp_in_data = '0;
      write_out = 1'b1; out_data = 8'h5A; out_ready = 1'b0;
      step(); step();
      checks += 2;
      if (out_valid !== 1'b1 || out_bus !== 8'h5A) begin
         failures++; $display("FAIL rst_pre_out got=%b/%h exp=1/5a", out_valid, out_bus);
      end
      #1 n_reset = 1'b0;
      #1;
      if (out_valid !== 1'b0 || out_bus !== 8'h00 || in_ack !== 1'b0 || timeout !== 1'b0) begin
         failures++; $display("FAIL rst_out_wait got=%b/%h/%b/%b exp=0/00/0/0", out_valid, out_bus, in_ack, timeout);
      end
      write_out = 1'b0;
      step();
      n_reset = 1'b1;
      do_idle(2);
      test_stin_ready();
   endtask

   task automatic test_random();
      int n;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: do_stin(int'($urandom_range(0, T + 2)), IB'($urandom), 1'b0, n);
            1: do_lout(int'($urandom_range(0, T + 2)), N'($urandom), n);
            default: do_stin(int'($urandom_range(0, 3)), IB'($urandom), 1'b1, n);
         endcase
         do_idle(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      exp_timeout = 1'b0; exp_out_bus = '0; exp_in_data = '0;
      test_reset();
      test_stin_ready();
      test_stin_delayed();
      test_lout();
      test_timeout();
      test_both_strobes();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
